// File: rtl/median_column_feeder_if.sv
// Pixel-in / column-out stream bundle for median_column_feeder.
// The master drives the raster pixel stream and observes the column outputs.
// The slave (the feeder) consumes pixels and produces column triples.
interface median_column_feeder_if #(
  parameter int PIX_W = 8
);
  // Raster input stream
  logic [PIX_W-1:0] pix_in;
  logic             pix_valid;
  logic             pix_sof;

  // Column output stream (top/mid/bottom feed sorter in0/in1/in2)
  logic [PIX_W-1:0] col_top;
  logic [PIX_W-1:0] col_mid;
  logic [PIX_W-1:0] col_bot;
  logic             col_valid;
  logic             col_sol;
  logic             col_eol;
  logic             col_eof;

  modport master (
    output pix_in, pix_valid, pix_sof,
    input  col_top, col_mid, col_bot, col_valid, col_sol, col_eol, col_eof
  );

  modport slave (
    input  pix_in, pix_valid, pix_sof,
    output col_top, col_mid, col_bot, col_valid, col_sol, col_eol, col_eof
  );
endinterface

// File: rtl/median_column_feeder.sv
// median_column_feeder: raster-to-column front end for the median filter.
// Buffers the two previous image lines and emits, one cycle after each
// accepted pixel, the vertically aligned triple (row r-2, r-1, r) at column c.
// Optional feature macro: MEDIAN_FEEDER_ZERO_PAD_EN
//   defined   -> rows 0 and 1 are emitted with zero-filled missing rows
//   undefined -> rows 0 and 1 are suppressed
module median_column_feeder #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int PIX_W      = 8
) (
  input logic                  clk,
  input logic                  rst,
  median_column_feeder_if.slave bus
);

  localparam int unsigned CW = $clog2(IMG_WIDTH);
  localparam int unsigned RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] C_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] R_LAST = RW'(IMG_HEIGHT - 1);

  // Position counters of the next expected pixel
  logic [CW-1:0] c_q;
  logic [RW-1:0] r_q;

  // Position of the pixel presented this cycle, and the advanced position
  logic [CW-1:0] pos_c;
  logic [RW-1:0] pos_r;
  logic [CW-1:0] c_nxt;
  logic [RW-1:0] r_nxt;

  // Line buffers: lb0 holds row r-1, lb1 holds row r-2
  logic [PIX_W-1:0] lb0 [IMG_WIDTH];
  logic [PIX_W-1:0] lb1 [IMG_WIDTH];
  logic [PIX_W-1:0] rd0;
  logic [PIX_W-1:0] rd1;

  // Decoded per-pixel attributes
  logic             accept;
  logic             row_full;
  logic             emit;
  logic             at_eol;
  logic             at_last_row;
  logic [PIX_W-1:0] top_d;
  logic [PIX_W-1:0] mid_d;

  // rst dominates pix_valid: a pixel presented during reset is dropped
  assign accept = bus.pix_valid && !rst;

  assign rd0 = lb0[pos_c];
  assign rd1 = lb1[pos_c];

  // Resolve the pixel position (sof forces 0,0) and compute the counter advance
  always_comb begin
    pos_c       = c_q;
    pos_r       = r_q;
    c_nxt       = c_q;
    r_nxt       = r_q;
    if (bus.pix_sof) begin
      pos_c = '0;
      pos_r = '0;
    end
    at_eol      = (pos_c == C_LAST);
    at_last_row = (pos_r == R_LAST);
    row_full    = (pos_r > RW'(1));
    if (at_eol) begin
      c_nxt = '0;
      r_nxt = at_last_row ? '0 : pos_r + RW'(1);
    end else begin
      c_nxt = pos_c + CW'(1);
      r_nxt = pos_r;
    end
  end

  // Output data selection; rows without a full window are padded or suppressed
  always_comb begin
`ifdef MEDIAN_FEEDER_ZERO_PAD_EN
    emit  = 1'b1;
    top_d = row_full ? rd1 : '0;
    mid_d = (pos_r == '0) ? '0 : rd0;
`else
    emit  = row_full;
    top_d = rd1;
    mid_d = rd0;
`endif
  end

  // Position counters: advance only on an accepted pixel
  always_ff @(posedge clk) begin
    if (rst) begin
      c_q <= '0;
      r_q <= '0;
    end else if (bus.pix_valid) begin
      c_q <= c_nxt;
      r_q <= r_nxt;
    end
  end

  // Line-buffer shift: read-before-write, one write per buffer, never cleared
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1[pos_c] <= rd0;
      lb0[pos_c] <= bus.pix_in;
    end
  end

  // Output register: one cycle latency; data holds across idle cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.col_valid <= 1'b0;
      bus.col_sol   <= 1'b0;
      bus.col_eol   <= 1'b0;
      bus.col_eof   <= 1'b0;
      bus.col_top   <= '0;
      bus.col_mid   <= '0;
      bus.col_bot   <= '0;
    end else begin
      bus.col_valid <= bus.pix_valid && emit;
      bus.col_sol   <= bus.pix_valid && emit && (pos_c == '0);
      bus.col_eol   <= bus.pix_valid && emit && at_eol;
      bus.col_eof   <= bus.pix_valid && emit && at_eol && at_last_row;
      if (bus.pix_valid) begin
        bus.col_top <= top_d;
        bus.col_mid <= mid_d;
        bus.col_bot <= bus.pix_in;
      end
    end
  end

endmodule

// File: tb/tb_median_column_feeder.sv
// Testbench for median_column_feeder on a 4x4 image.
// Driver pushes hand-derived expected columns into a queue; an independent
// monitor pops and compares whenever col_valid is seen.
module tb_median_column_feeder;

  localparam int W = 4;
  localparam int H = 4;
  localparam int PW = 8;

  typedef struct packed {
    logic [PW-1:0] top;
    logic [PW-1:0] mid;
    logic [PW-1:0] bot;
    logic          sol;
    logic          eol;
    logic          eof;
  } col_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic acc_d = 1'b0;
  col_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  median_column_feeder_if #(.PIX_W(PW)) bus ();

  median_column_feeder #(
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H),
    .PIX_W     (PW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Remember whether a pixel was accepted at the last rising edge
  always @(posedge clk) acc_d <= bus.pix_valid && !rst;

  // Monitor: compare every presented column against the scoreboard
  always @(negedge clk) begin
    col_t e;
    col_t a;
    if (bus.col_valid === 1'b1) begin
      a = '{bus.col_top, bus.col_mid, bus.col_bot, bus.col_sol, bus.col_eol, bus.col_eof};
      tests++;
      if (!acc_d) begin
        fails++;
        $display("FAIL valid_pulse: col_valid=1 without an accepted pixel, required 0");
      end
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_col: got top=%0d mid=%0d bot=%0d, required no output",
                 a.top, a.mid, a.bot);
      end else begin
        e = exp_q.pop_front();
        if (a !== e) begin
          fails++;
          $display("FAIL column: got t/m/b=%0d/%0d/%0d s/e/f=%b%b%b, required %0d/%0d/%0d %b%b%b",
                   a.top, a.mid, a.bot, a.sol, a.eol, a.eof,
                   e.top, e.mid, e.bot, e.sol, e.eol, e.eof);
        end
      end
    end
  end

  // Push the expected column for a pixel at (r,c); top/mid are hand-derived
  task automatic expect_px(input int r, input int c, input int top, input int mid, input int bot);
    col_t e;
    logic eol;
    eol = (c == W - 1);
    e = '{PW'(top), PW'(mid), PW'(bot), (c == 0), eol, eol && (r == H - 1)};
    if (r >= 2) exp_q.push_back(e);
`ifdef MEDIAN_FEEDER_ZERO_PAD_EN
    else begin
      e.top = '0;
      if (r == 0) e.mid = '0;
      exp_q.push_back(e);
    end
`endif
  endtask

  task automatic send(input int p, input logic sof);
    @(negedge clk);
    bus.pix_in    = PW'(p);
    bus.pix_valid = 1'b1;
    bus.pix_sof   = sof;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.pix_valid = 1'b0;
      bus.pix_sof   = 1'b0;
    end
  endtask

  // Frame of base+1..base+16; pixel p at index i sits at (i/4, i%4)
  task automatic frame(input int base, input logic sof, input logic gaps);
    for (int i = 0; i < W * H; i++) begin
      expect_px(i / W, i % W, base + i + 1 - 2 * W, base + i + 1 - W, base + i + 1);
      send(base + i + 1, sof && (i == 0));
      if (gaps) idle(1);
    end
  endtask

  task automatic check_zero(input string name);
    tests++;
    if (bus.col_valid !== 1'b0 || bus.col_top !== '0 || bus.col_mid !== '0 ||
        bus.col_bot !== '0 || bus.col_sol !== 1'b0 || bus.col_eol !== 1'b0 ||
        bus.col_eof !== 1'b0) begin
      fails++;
      $display("FAIL %s: got valid=%b t/m/b=%0d/%0d/%0d, required all zero",
               name, bus.col_valid, bus.col_top, bus.col_mid, bus.col_bot);
    end
  endtask

  initial begin
    bus.pix_in    = '0;
    bus.pix_valid = 1'b0;
    bus.pix_sof   = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_zero("reset_state");
    rst = 1'b0;

    // Basic streaming with sof, valid held high
    frame(0, 1'b1, 1'b0);
    idle(2);

    // Same frame with one idle cycle after each pixel
    frame(0, 1'b1, 1'b1);
    idle(2);

    // Second frame without sof: counters wrapped on their own
    frame(100, 1'b0, 1'b0);
    idle(2);

    // Mid-frame sof after pixel 11
    for (int i = 0; i < 11; i++) begin
      expect_px(i / W, i % W, i + 1 - 2 * W, i + 1 - W, i + 1);
      send(i + 1, i == 0);
    end
    frame(200, 1'b1, 1'b0);
    idle(2);

    // Reset together with a valid pixel after pixel 10
    for (int i = 0; i < 10; i++) begin
      expect_px(i / W, i % W, i + 1 - 2 * W, i + 1 - W, i + 1);
      send(i + 1, i == 0);
    end
    @(negedge clk);
    bus.pix_in    = PW'(11);
    bus.pix_valid = 1'b1;
    bus.pix_sof   = 1'b0;
    rst           = 1'b1;
    @(negedge clk);
    rst           = 1'b0;
    bus.pix_valid = 1'b0;
    check_zero("after_rst");
    frame(0, 1'b0, 1'b0);
    idle(3);

    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expected columns never appeared, required 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, required finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/median_column_feeder.md
Name: median_column_feeder

Overview:
- Raster-to-column front end for the median filter datapath.
- Accepts one 8-bit pixel per cycle in raster order, buffers the two previous image lines, and emits three vertically aligned pixels per accepted pixel.
- The three column pixels feed the 3-input ascending sorters directly as in0/in1/in2 (top/mid/bottom).
- Valid-only stream; no backpressure in either direction.

Parameters:
- IMG_WIDTH, 640, pixels per line; legal range 4..4096.
- IMG_HEIGHT, 480, lines per frame; legal range 3..4096.
- PIX_W, 8, pixel width in bits.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- pix_in  input  PIX_W  incoming pixel.
- pix_valid  input  1  pix_in is valid this cycle.
- pix_sof  input  1  start of frame; sampled only when pix_valid=1.
- col_top  output  PIX_W  pixel from row r-2, column c.
- col_mid  output  PIX_W  pixel from row r-1, column c.
- col_bot  output  PIX_W  pixel from row r, column c.
- col_valid  output  1  column outputs valid.
- col_sol  output  1  column is c=0; qualified by col_valid.
- col_eol  output  1  column is c=IMG_WIDTH-1; qualified by col_valid.
- col_eof  output  1  column is last of frame (r=IMG_HEIGHT-1, c=IMG_WIDTH-1); qualified by col_valid.

Behaviour:
- Reset:
  - col_valid, col_sol, col_eol, col_eof = 0; col_top/mid/bot = 0.
  - Column counter c = 0, row counter r = 0.
  - Line-buffer RAM contents are not cleared.
- Storage: two line buffers, lb0 (row r-1) and lb1 (row r-2), each IMG_WIDTH x PIX_W, indexed by c. Inferable as RAM: one read and one write per buffer per cycle.
- Position of each accepted pixel (pix_valid=1):
  - If pix_sof=1, the pixel is (0,0).
  - Otherwise it takes the current (r,c).
- On acceptance, in the same cycle:
  - Read lb1[c] and lb0[c].
  - Write lb1[c] <= lb0[c] and lb0[c] <= pix_in (read-before-write).
- Output register, loaded 1 cycle after acceptance (latency 1):
  - col_top = old lb1[c], col_mid = old lb0[c], col_bot = pix_in.
  - col_valid = 1 iff r >= 2.
  - col_sol, col_eol and col_eof decoded from the (r,c) of that pixel.
- Cycles with pix_valid=0: counters and RAM hold; col_valid = 0 next cycle. Data outputs hold their last value.
- Counter advance after each accepted pixel:
  - c increments.
  - At c=IMG_WIDTH-1: c wraps to 0 and r increments.
  - At r=IMG_HEIGHT-1, c=IMG_WIDTH-1: both wrap to 0, so the next frame starts automatically even without sof.
- Mid-frame pix_sof=1: aborts the current frame.
  - The pixel is taken as (0,0); the counters restart from there.
  - Rows 0 and 1 of the new frame are suppressed again, so stale buffer contents never reach the outputs.
- Reset asserted mid-frame: outputs clear next cycle; the next accepted pixel is (0,0) regardless of pix_sof.
- pix_valid and rst in the same cycle: rst wins; the pixel is dropped and the RAM is not written.
- Counter widths: clog2(IMG_WIDTH) and clog2(IMG_HEIGHT); no other arithmetic.

Optional Feature:
- Macro: MEDIAN_FEEDER_ZERO_PAD_EN.
- Defined:
  - Rows 0 and 1 are also emitted, with col_valid=1.
  - Row 0: col_top=0 and col_mid=0.
  - Row 1: col_top=0.
  - Output count per frame is IMG_WIDTH*IMG_HEIGHT.
- Undefined:
  - Rows 0 and 1 are suppressed.
  - Output count per frame is IMG_WIDTH*(IMG_HEIGHT-2).
- Counter, RAM and latency behaviour are identical in both builds.

Test Plan:
- Basic streaming: IMG_WIDTH=4, IMG_HEIGHT=4. Send pixels 1..16 with sof on pixel 1 and pix_valid held 1.
  - No col_valid for pixels 1..8.
  - The cycle after pixel 9: top=1, mid=5, bot=9, sol=1.
  - Pixel 16: top=8, mid=12, bot=16, eol=1, eof=1.
- Gaps: same frame with pix_valid toggled 1,0,1,0.
  - Identical output sequence; col_valid pulses only 1 cycle after each accepted pixel.
- Auto-wrap: send a second frame 101..116 with no sof.
  - Nothing emitted for 101..108.
  - First valid output: top=101, mid=105, bot=109.
- Mid-frame sof: after pixel 11 of frame 1, send sof with 201 followed by 202..216.
  - No outputs until pixel 209.
  - At pixel 209: top=201, mid=205, bot=209.
- Reset mid-frame: assert rst for 1 cycle after pixel 10 together with pix_valid=1.
  - That pixel is dropped; col_valid=0 the next cycle.
  - The next pixel is (0,0); outputs resume only at row 2.
- Zero-pad build (MEDIAN_FEEDER_ZERO_PAD_EN): basic streaming stimulus.
  - Pixel 1 gives top=0, mid=0, bot=1, valid=1.
  - Pixel 5 gives top=0, mid=1, bot=5.
  - 16 valid outputs total.
